// File: rtl/pipeline_layer4_ctrl.sv
// Sequencing controller for the layer-4 adder-tree / bias / ReLU pipeline.
// A token shift register follows each accepted vector; output backpressure freezes the whole pipe.
module pipeline_layer4_ctrl #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned STAGES    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_num,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 valid_in_bias,
  output logic [STAGES-2:0]    valid_pipeline,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] job_len_q, job_len_d;
  logic [CNT_WIDTH-1:0] in_count_q, in_count_d;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
  logic [STAGES-1:0]    tok_q, tok_d;

  logic stall;
  logic accept;
  logic consume;
  logic [CNT_WIDTH-1:0] in_count_inc;
  logic [CNT_WIDTH-1:0] out_count_inc;

  always_comb begin
    out_valid      = tok_q[STAGES-1];
    stall          = out_valid & ~out_ready;
    in_ready       = (state_q == StRun) & ~stall & (in_count_q < job_len_q);
    accept         = in_valid & in_ready;
    consume        = out_valid & out_ready;
    valid_in_bias  = accept;
    // Bubbles keep their enable low; a stall drops every enable so all registers hold.
    valid_pipeline = tok_q[STAGES-2:0] & {(STAGES-1){~stall}};
    out_count      = out_count_q;
    busy           = (state_q == StRun) | (state_q == StDrain);
    done           = (state_q == StDone);
    in_count_inc   = in_count_q + CntOne;
    out_count_inc  = out_count_q + CntOne;
  end

  always_comb begin
    state_d     = state_q;
    job_len_d   = job_len_q;
    in_count_d  = in_count_q;
    out_count_d = out_count_q;
    tok_d       = stall ? tok_q : {tok_q[STAGES-2:0], accept};

    if (accept) begin
      in_count_d = in_count_inc;
    end
    if (consume) begin
      out_count_d = out_count_inc;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          job_len_d   = cfg_num;
          in_count_d  = '0;
          out_count_d = '0;
          state_d     = (cfg_num == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept && (in_count_inc == job_len_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (consume && (out_count_inc == job_len_q)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      job_len_q   <= '0;
      in_count_q  <= '0;
      out_count_q <= '0;
      tok_q       <= '0;
    end else begin
      state_q     <= state_d;
      job_len_q   <= job_len_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      tok_q       <= tok_d;
    end
  end

endmodule

// File: tb/tb_pipeline_layer4_ctrl.sv
// Bench for pipeline_layer4_ctrl: a queue-of-ages job model checked every cycle,
// plus hand-computed event timings for the directed jobs.
module tb_pipeline_layer4_ctrl;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_num;
  logic          in_valid;
  logic          in_ready;
  logic          valid_in_bias;
  logic [4:0]    valid_pipeline;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pipeline_layer4_ctrl #(
    .CNT_WIDTH(CW),
    .STAGES   (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_num       (cfg_num),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .valid_in_bias (valid_in_bias),
    .valid_pipeline(valid_pipeline),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_count     (out_count),
    .busy          (busy),
    .done          (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Job model: phase 0 idle, 1 job active, 2 done pulse; ages = edges travelled per in-flight vector.
  int m_phase = 0;
  int m_len   = 0;
  int m_in    = 0;
  int m_out   = 0;
  int ages[$];

  int   cyc;
  int   o_first_vib, o_first_ov, o_done_cyc, o_done_cnt, o_last_acc;
  int   o_first_vp[5];
  int   o_in_ready_n, o_acc_n, o_ov_n, o_ov_rises, o_stall_n, o_stall_en, o_en_n;
  logic prev_ov;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    cyc          = 0;
    o_first_vib  = -1;
    o_first_ov   = -1;
    o_done_cyc   = -1;
    o_done_cnt   = -1;
    o_last_acc   = -1;
    for (int k = 0; k < 5; k++) o_first_vp[k] = -1;
    o_in_ready_n = 0;
    o_acc_n      = 0;
    o_ov_n       = 0;
    o_ov_rises   = 0;
    o_stall_n    = 0;
    o_stall_en   = 0;
    o_en_n       = 0;
    prev_ov      = 1'b0;
  endtask

  // One clock: compare at negedge, advance the model, return #1 after the rising edge.
  task automatic step();
    logic       e_ov, e_stall, e_ir, e_acc, e_consume;
    logic [4:0] e_vp;
    logic [9:0] e_vec, a_vec;
    @(negedge clk);
    e_ov    = (ages.size() > 0) && (ages[0] == 6);
    e_stall = e_ov && !out_ready;
    e_ir    = (m_phase == 1) && (m_in < m_len) && !e_stall;
    e_acc   = in_valid && e_ir;
    e_vp    = '0;
    if (!e_stall) begin
      foreach (ages[i]) if (ages[i] >= 1 && ages[i] <= 5) e_vp[ages[i]-1] = 1'b1;
    end
    e_vec = {e_ir, e_acc, e_vp, e_ov, (m_phase == 1), (m_phase == 2)};
    a_vec = {in_ready, valid_in_bias, valid_pipeline, out_valid, busy, done};
    n_cmp++;
    if (a_vec !== e_vec) begin
      n_fail++;
      $display("FAIL ctrl@%0t {ir,vib,vp,ov,busy,done}: got %b, expected %b", $time, a_vec, e_vec);
    end
    n_cmp++;
    if (out_count !== CW'(m_out)) begin
      n_fail++;
      $display("FAIL out_count@%0t: got %0d, expected %0d", $time, out_count, m_out);
    end

    if (valid_in_bias && o_first_vib < 0) o_first_vib = cyc;
    for (int k = 0; k < 5; k++) if (valid_pipeline[k] && o_first_vp[k] < 0) o_first_vp[k] = cyc;
    if (out_valid && o_first_ov < 0) o_first_ov = cyc;
    if (done && o_done_cyc < 0) begin
      o_done_cyc = cyc;
      o_done_cnt = int'(out_count);
    end
    if (in_ready) o_in_ready_n++;
    if (valid_in_bias) begin
      o_acc_n++;
      o_last_acc = cyc;
    end
    if (out_valid && out_ready) o_ov_n++;
    if (out_valid && !prev_ov) o_ov_rises++;
    prev_ov = out_valid;
    if (out_valid && !out_ready) begin
      o_stall_n++;
      if (in_ready || valid_in_bias || valid_pipeline != 5'd0) o_stall_en++;
    end
    if (in_ready || valid_in_bias || valid_pipeline != 5'd0) o_en_n++;

    if (rst) begin
      m_phase = 0;
      m_in    = 0;
      m_out   = 0;
      ages.delete();
    end else begin
      e_consume = e_ov && out_ready;
      if (e_consume) begin
        void'(ages.pop_front());
        m_out++;
      end
      if (!e_stall) foreach (ages[i]) ages[i]++;
      if (e_acc) begin
        ages.push_back(1);
        m_in++;
      end
      case (m_phase)
        0: if (start) begin
          m_len   = int'(cfg_num);
          m_in    = 0;
          m_out   = 0;
          m_phase = (cfg_num == '0) ? 2 : 1;
        end
        1: if (e_consume && m_out == m_len) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: streaming; 1: out_ready low cycles 7..10; 2: random in_valid; 3: start retried at cyc 2
  task automatic run_job(input int len, input int mode, input int budget);
    start    = 1'b1;
    cfg_num  = CW'(len);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    clear_obs();
    for (int i = 0; i < budget && o_done_cyc < 0; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      start     = 1'b0;
      case (mode)
        1: out_ready = !(cyc >= 7 && cyc <= 10);
        2: in_valid = 1'($urandom_range(0, 1));
        3: begin
          start   = (cyc == 2);
          cfg_num = 16'd9;
        end
        default: ;
      endcase
      step();
    end
    check("job_done_seen", int'(o_done_cyc >= 0), 1);
    start    = 1'b0;
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    cfg_num   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_obs();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out_count", int'(out_count), 0);
    step();

    // Single vector: the token walks the stages one per cycle.
    run_job(1, 0, 40);
    check("t1_vib_cycle", o_first_vib, 0);
    for (int k = 0; k < 5; k++) check($sformatf("t1_vp%0d_cycle", k), o_first_vp[k], k + 1);
    check("t1_out_valid_cycle", o_first_ov, 6);
    check("t1_done_cycle", o_done_cyc, 7);
    check("t1_done_count", o_done_cnt, 1);

    // Streaming 20 vectors at full rate.
    run_job(20, 0, 80);
    check("t2_in_ready_cycles", o_in_ready_n, 20);
    check("t2_last_accept", o_last_acc, 19);
    check("t2_results", o_ov_n, 20);
    check("t2_out_valid_runs", o_ov_rises, 1);
    check("t2_done_after_last", o_done_cyc - o_last_acc, 7);
    check("t2_done_count", o_done_cnt, 20);

    // Full-pipe stall for 4 cycles.
    run_job(8, 1, 80);
    check("t3_stall_cycles", o_stall_n, 4);
    check("t3_enables_in_stall", o_stall_en, 0);
    check("t3_results", o_ov_n, 8);
    check("t3_done_cycle", o_done_cyc, 18);
    check("t3_done_count", o_done_cnt, 8);

    // Random input gaps.
    run_job(10, 2, 300);
    check("t4_accepts", o_acc_n, 10);
    check("t4_results", o_ov_n, 10);
    check("t4_done_count", o_done_cnt, 10);

    // Empty job, then a start pulse while busy.
    run_job(0, 0, 10);
    check("t5_zero_done_cycle", o_done_cyc, 0);
    check("t5_zero_enables", o_en_n, 0);
    run_job(3, 3, 40);
    check("t5_busy_start_accepts", o_acc_n, 3);
    check("t5_busy_start_done_cycle", o_done_cyc, 9);
    check("t5_busy_start_count", o_done_cnt, 3);

    // Reset with three tokens in flight.
    start    = 1'b1;
    cfg_num  = 16'd10;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    clear_obs();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_out_count", int'(out_count), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_in_ready", int'(in_ready), 0);
    check("t6_done", int'(done), 0);
    clear_obs();
    repeat (10) step();
    check("t6_no_done", o_done_cyc, -1);
    run_job(2, 0, 40);
    check("t6_rerun_done_cycle", o_done_cyc, 8);
    check("t6_rerun_count", o_done_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
